// File: rtl/rfi_ctrl_pkg.sv
// Shared definitions for the rfi_detection sequencer: state encoding, reset length
// and the end-of-spectrum channel test.
package rfi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  localparam int unsigned DEFAULT_ACC_LEN = 1024;

  // True when cnt is the last channel of a spectrum of 2^addr_w channels.
  function automatic logic chan_last(input logic [31:0] cnt, input int unsigned addr_w);
    return cnt == ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rfi_chan_counter.sv
// Channel/spectrum counters for one integration; flags the last sample of the
// integration (boundary) combinationally so the top level can register it.
module rfi_chan_counter
  import rfi_ctrl_pkg::*;
#(
  parameter int CHANNEL_ADDR = 9,
  parameter int LEN_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  input  logic [LEN_WIDTH-1:0]    acc_len,
  output logic [CHANNEL_ADDR-1:0] chan_cnt,
  output logic                    boundary
);

  logic [LEN_WIDTH-1:0] spec_cnt;
  logic                 last;

  assign last     = chan_last(32'(chan_cnt), CHANNEL_ADDR);
  assign boundary = en && last && (spec_cnt == acc_len - LEN_WIDTH'(1));

  // chan_cnt holds the channel of the next valid sample; the start sample is channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      chan_cnt <= '0;
      spec_cnt <= '0;
    end else if (start) begin
      chan_cnt <= CHANNEL_ADDR'(1);
      spec_cnt <= '0;
    end else if (en) begin
      if (last) begin
        chan_cnt <= '0;
        spec_cnt <= boundary ? '0 : spec_cnt + LEN_WIDTH'(1);
      end else begin
        chan_cnt <= chan_cnt + CHANNEL_ADDR'(1);
      end
    end
  end

endmodule

// File: rtl/rfi_acc_sequencer.sv
// Integration sequencer for rfi_detection: sync alignment, boundary-safe acc_len updates.
// Optional misaligned-sync detection is enabled with `define RFI_SEQ_SYNC_CHECK_EN.
module rfi_acc_sequencer
  import rfi_ctrl_pkg::*;
#(
  parameter int CHANNEL_ADDR    = 9,
  parameter int LEN_WIDTH       = 32,
  parameter int DEFAULT_ACC_LEN = rfi_ctrl_pkg::DEFAULT_ACC_LEN,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync_in,
  input  logic                     din_valid,
  input  logic                     arm,
  input  logic [LEN_WIDTH-1:0]     acc_len_req,
  input  logic                     acc_len_load,
  output logic [LEN_WIDTH-1:0]     acc_len,
  output logic                     cnt_rst,
  output logic [CHANNEL_ADDR-1:0]  chan_idx,
  output logic                     acc_done,
  output logic                     running,
  output logic                     cfg_err,
  output logic                     sync_err,
  output logic [ERR_CNT_WIDTH-1:0] sync_err_cnt
);

  seq_state_e            state, state_nxt;
  logic                  pend_vld;
  logic [LEN_WIDTH-1:0]  pend_len;
  logic [CHANNEL_ADDR-1:0] chan_cnt;
  logic                  boundary;
  logic                  seq_start, misalign, cnt_en;
  logic                  load_ok, eff_vld, apply;
  logic [LEN_WIDTH-1:0]  eff_len;

`ifdef RFI_SEQ_SYNC_CHECK_EN
  assign misalign = (state == RUN) && din_valid && sync_in && (chan_cnt != '0);
`else
  assign misalign = 1'b0;
`endif

  rfi_chan_counter #(
    .CHANNEL_ADDR (CHANNEL_ADDR),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_chan_counter (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start || misalign),
    .en       (cnt_en),
    .acc_len  (acc_len),
    .chan_cnt (chan_cnt),
    .boundary (boundary)
  );

  always_comb begin
    state_nxt = state;
    seq_start = 1'b0;
    cnt_en    = (state == RUN) && din_valid && !misalign;
    load_ok   = acc_len_load && (acc_len_req != '0);
    eff_vld   = pend_vld || load_ok;
    eff_len   = load_ok ? acc_len_req : pend_len;
    // Outside RUN nothing is being integrated, so a pending length can land at once.
    apply     = eff_vld && ((state != RUN) || boundary);
    case (state)
      IDLE: begin
        if (arm) state_nxt = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (sync_in && din_valid) begin
          state_nxt = RUN;
          seq_start = 1'b1;
        end
      end
      RUN: begin
        if (boundary && !arm) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc_len  <= LEN_WIDTH'(DEFAULT_ACC_LEN);
      pend_vld <= 1'b0;
      cnt_rst  <= 1'b0;
      acc_done <= 1'b0;
      cfg_err  <= 1'b0;
      chan_idx <= '0;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (apply) acc_len <= eff_len;
      pend_vld <= eff_vld && !apply;
      // A disarming boundary leaves the accumulators alone; the next sync clears them.
      cnt_rst  <= seq_start || misalign || (apply && ((state != RUN) || arm));
      acc_done <= boundary;
      cfg_err  <= acc_len_load && (acc_len_req == '0);
      running  <= (state_nxt == RUN);
      if (seq_start || misalign) begin
        chan_idx <= '0;
      end else if (cnt_en) begin
        chan_idx <= chan_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) pend_len <= acc_len_req;
  end

`ifdef RFI_SEQ_SYNC_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err     <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      sync_err <= misalign;
      if (misalign && (sync_err_cnt != '1)) sync_err_cnt <= sync_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end
`else
  assign sync_err     = 1'b0;
  assign sync_err_cnt = '0;
`endif

endmodule
